alu_issue_queue: RTL

Upstream issue stage for the 5-bit ALU (alu8inst). It buffers incoming instructions (opcode, a, b) in a small FIFO and presents the head entry to the combinational ALU. It captures the ALU result into a registered output stage with a valid/ready handshake. This decouples the instruction source from the result consumer and gives a throughput of one instruction per cycle.

---
 rtl/alu_issue_if.sv | 28 ++
 rtl/alu_issue_queue.sv | 118 +++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// Issue-side and result-side handshake bundle for alu_issue_queue.
// A transfer happens on a rising clk edge where valid and ready are both 1.
// valid and its payload stay stable until that edge, and ready never depends on valid.
interface alu_issue_if #(
  parameter int OP_W  = 3,
  parameter int D_W   = 5,
  parameter int RES_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_opcode;
  logic [D_W-1:0]   in_a;
  logic [D_W-1:0]   in_b;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_result;
  logic [OP_W-1:0]  out_opcode;

  modport master (
    output in_valid, in_opcode, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_opcode
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_opcode
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Instruction FIFO that feeds a combinational ALU and registers its result
// behind a valid/ready output stage. Sustains one instruction per cycle.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int OP_W  = 3,
  parameter int D_W   = 5,
  parameter int RES_W = 10,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  alu_issue_if.slave                 bus,
  output logic [OP_W-1:0]            alu_opcode,
  output logic [D_W-1:0]             alu_a,
  output logic [D_W-1:0]             alu_b,
  input  logic [RES_W-1:0]           alu_result,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           done_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int ENT_W = OP_W + 2 * D_W;
  localparam logic [OCC_W-1:0] FULL_C = OCC_W'(DEPTH);

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             r_out_valid;
  logic [RES_W-1:0] r_out_result;
  logic [OP_W-1:0]  r_out_opcode;
  logic [CNT_W-1:0] r_done_count;

  logic             w_in_ready;
  logic             w_push;
  logic             w_nonempty;
  logic             w_load;
  logic             w_accept;
  logic [ENT_W-1:0] w_head;
  logic [OP_W-1:0]  w_head_op;
  logic [D_W-1:0]   w_head_a;
  logic [D_W-1:0]   w_head_b;

  // in_ready looks only at occupancy, so a full queue stays closed even on a pop cycle.
  assign w_in_ready = (r_count != FULL_C);
  assign w_push     = bus.in_valid & w_in_ready;
  assign w_nonempty = (r_count != '0);
  assign w_accept   = r_out_valid & bus.out_ready;
  // Using registered occupancy means a freshly pushed entry must become the head before it pops.
  assign w_load     = w_nonempty & (~r_out_valid | bus.out_ready);

  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_op = w_head[ENT_W-1 -: OP_W];
  assign w_head_a  = w_head[2*D_W-1 -: D_W];
  assign w_head_b  = w_head[D_W-1:0];

  assign alu_opcode = w_nonempty ? w_head_op : '0;
  assign alu_a      = w_nonempty ? w_head_a  : '0;
  assign alu_b      = w_nonempty ? w_head_b  : '0;

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_opcode = r_out_opcode;
  assign count          = r_count;
  assign done_count     = r_done_count;

  // Storage carries no reset; occupancy and pointers alone decide what is live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.in_opcode, bus.in_a, bus.in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_opcode <= '0;
    end else if (w_load) begin
      r_out_valid  <= 1'b1;
      r_out_result <= alu_result;
      r_out_opcode <= w_head_op;
    end else if (w_accept) begin
      r_out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_count <= '0;
    end else if (w_accept) begin
      r_done_count <= r_done_count + CNT_W'(1);
    end
  end

endmodule
